program_loader: RTL and testbench
=================================

# program_loader

Sequencer that owns the shared 8-bit bus while the CPU is held and writes a program into the 16-entry memory, one byte per handshake from an external byte source (debug/UART front end). For each byte it drives the address onto the bus, strobes the memory-address register, then drives the data byte and strobes the memory write. It sits beside the controller and asserts a hold so the CPU clock is halted and the controller does not drive the bus while loading.

## Interface
- DEPTH, 16, number of memory locations loaded per run (power of two, ≤ 2^ADDR_W)
- ADDR_W, 4, address width; matches memory-address register low nibble
- DATA_W, 8, bus/data width
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle request to begin a load; ignored unless IDLE
- i_abort  in  1  stop the load; wins over every other input
- i_valid  in  1  byte source has i_data valid
- i_data  in  DATA_W  program byte
- o_ready  out  1  loader accepts a byte this cycle
- o_bus  out  DATA_W  value to drive on shared bus
- o_bus_en  out  1  1 = top level enables o_bus onto bus; 0 = high-Z
- o_reg_mem_write_n  out  1  active-low load of memory-address register
- o_mem_write_n  out  1  active-low memory write strobe
- o_cpu_hold  out  1  1 = halt CPU clock and keep controller off bus
- o_busy  out  1  1 while not IDLE
- o_done  out  1  one-cycle pulse after final byte written
- o_addr  out  ADDR_W  address of byte currently being loaded

## Operation
- States: IDLE, ADDR, WAIT, DATA, DONE; state register plus addr counter (ADDR_W) plus data register (DATA_W).
- IDLE: all strobes high, o_bus_en=0, o_cpu_hold=0, o_ready=0. i_start=1 -> ADDR, addr cleared to 0.
- ADDR: o_bus={0,addr} zero-extended, o_bus_en=1, o_reg_mem_write_n=0. Always -> WAIT.
- WAIT: o_ready=1, o_bus_en=0. i_valid=1 -> latch i_data, -> DATA; else stay.
- DATA: o_bus=latched byte, o_bus_en=1, o_mem_write_n=0. If addr==DEPTH-1 -> DONE, else addr+1 -> ADDR.
- DONE: o_done=1 for exactly this cycle, o_cpu_hold still 1, -> IDLE.
- o_cpu_hold=1 and o_busy=1 in ADDR, WAIT, DATA, DONE.
- Never more than one strobe low in a cycle; o_bus_en=1 only in ADDR and DATA; o_bus=0 whenever o_bus_en=0.
- i_abort=1 in any non-IDLE state -> IDLE next cycle, no o_done, addr retained for inspection until next start; a memory location whose DATA cycle did not occur keeps its old contents.
- i_start while busy: ignored. i_start and i_abort together in IDLE: stay IDLE.
- Addr arithmetic modulo 2^ADDR_W; final-byte test uses DEPTH-1, so wrap never occurs within a run.

## Timing
- All outputs decoded from registered state/addr/data; o_ready is state decode only (no combinational path from i_valid).
- Reset (i_reset=0, asynchronous): state=IDLE, addr=0, data=0; o_bus=0, o_bus_en=0, o_reg_mem_write_n=1, o_mem_write_n=1, o_cpu_hold=0, o_busy=0, o_done=0, o_ready=0, o_addr=0. Reset mid-load abandons the run the same way as abort.
- Start at cycle N -> ADDR at N+1 (hold asserted from N+1).
- Per byte: ADDR 1 cycle, WAIT ≥1 cycle, DATA 1 cycle; minimum 3 cycles/byte with i_valid held high.
- Handshake: transfer on the rising edge where o_ready=1 and i_valid=1; source holds i_data until then.
- Full run with i_valid constantly high: start at N, o_done at N+3·DEPTH+1, IDLE (hold released) at N+3·DEPTH+2.
- Strobes low for exactly one cycle and sampled by register/memory on the closing edge, matching the CPU's write_n timing.

## Test plan
- Reset: drive i_reset=0 mid-DATA -> all outputs at reset values immediately, IDLE after release, memory entry not written.
- Full load, i_valid=1 always, bytes 0x10..0x1F -> o_done at start+49, memory[k]=0x10+k for k=0..15, hold high cycles start+1..start+49.
- Stalled source: i_valid low 5 cycles in WAIT for byte 3 -> o_ready stays 1, no strobes, o_bus_en=0, state holds; byte accepted on first valid cycle, total run +5 cycles.
- Abort in WAIT at addr=7 -> IDLE next cycle, o_done never pulses, o_cpu_hold=0, o_addr=7, memory[0..6] new, memory[7..15] unchanged.
- i_start pulsed during load at addr=4 -> no restart, addresses continue 5..15, single o_done.
- Bus check each cycle: o_bus_en=1 only with one strobe low; ADDR cycles show o_bus=0x00..0x0F in order; never both strobes low together.

Source files
------------

// File: rtl/program_loader.sv
// Program loader: holds the CPU and writes DEPTH bytes from an external byte
// source into memory, one address-register strobe plus one memory-write strobe per byte.
module program_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_bus,
    output logic              o_bus_en,
    output logic              o_reg_mem_write_n,
    output logic              o_mem_write_n,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   data_q,  data_d;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_ADDR;
                    addr_d  = '0;
                end
            end
            S_ADDR: state_d = S_WAIT;
            S_WAIT: begin
                if (i_valid) begin
                    data_d  = i_data;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (addr_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything; addr is kept so the stopping point can be inspected.
        if (i_abort) begin
            state_d = S_IDLE;
            addr_d  = addr_q;
            data_d  = data_q;
        end
    end

    // All outputs are pure decodes of registered state, so strobes are glitch-free.
    always_comb begin
        o_ready           = 1'b0;
        o_bus             = '0;
        o_bus_en          = 1'b0;
        o_reg_mem_write_n = 1'b1;
        o_mem_write_n     = 1'b1;
        o_done            = 1'b0;
        o_busy            = (state_q != S_IDLE);
        o_cpu_hold        = (state_q != S_IDLE);
        o_addr            = addr_q;
        case (state_q)
            S_ADDR: begin
                o_bus             = {{(DATA_W-ADDR_W){1'b0}}, addr_q};
                o_bus_en          = 1'b1;
                o_reg_mem_write_n = 1'b0;
            end
            S_WAIT: o_ready = 1'b1;
            S_DATA: begin
                o_bus         = data_q;
                o_bus_en      = 1'b1;
                o_mem_write_n = 1'b0;
            end
            S_DONE:  o_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: per-cycle vector table plus multi-cycle load scenarios
// against a small model of the address register and 16-entry memory.
module tb_program_loader;

    logic       i_clk, i_reset, i_start, i_abort, i_valid;
    logic [7:0] i_data;
    logic       o_ready, o_bus_en, o_reg_mem_write_n, o_mem_write_n;
    logic       o_cpu_hold, o_busy, o_done;
    logic [7:0] o_bus;
    logic [3:0] o_addr;

    int n_chk = 0;
    int n_fail = 0;
    int bus_viol = 0;

    program_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_abort(i_abort),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready), .o_bus(o_bus),
        .o_bus_en(o_bus_en), .o_reg_mem_write_n(o_reg_mem_write_n),
        .o_mem_write_n(o_mem_write_n), .o_cpu_hold(o_cpu_hold), .o_busy(o_busy),
        .o_done(o_done), .o_addr(o_addr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Memory-address register and memory, written on the edge that closes each strobe.
    logic [7:0] mem [16];
    logic [3:0] mar;
    logic       clr_mem = 1'b0;
    always @(posedge i_clk) begin
        if (clr_mem) begin
            for (int k = 0; k < 16; k++) mem[k] <= 8'hEE;
        end else begin
            if (!o_reg_mem_write_n) mar <= o_bus[3:0];
            if (!o_mem_write_n) mem[mar] <= o_bus;
        end
    end

    // Bus rules observed every cycle.
    always @(negedge i_clk) begin
        if (!o_reg_mem_write_n && !o_mem_write_n) bus_viol++;
        if (o_bus_en != (!o_reg_mem_write_n || !o_mem_write_n)) bus_viol++;
        if (!o_bus_en && o_bus != 8'h00) bus_viol++;
        if (o_cpu_hold != o_busy) bus_viol++;
    end

    typedef struct {
        logic       st, ab, vl;
        logic [7:0] dt;
        logic       rdy;
        logic [7:0] bus;
        logic       en, rn, mn, hold, busy, done;
        logic [3:0] addr;
    } vec_t;

    localparam logic [18:0] RST_OUT = {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0};

    function automatic logic [18:0] outs();
        return {o_ready, o_bus, o_bus_en, o_reg_mem_write_n, o_mem_write_n,
                o_cpu_hold, o_busy, o_done, o_addr};
    endfunction

    function automatic vec_t mk(int st, int ab, int vl, int dt, int rdy, int bus, int en,
                                int rn, int mn, int hold, int busy, int done, int addr);
        vec_t v;
        v.st = st[0]; v.ab = ab[0]; v.vl = vl[0]; v.dt = dt[7:0];
        v.rdy = rdy[0]; v.bus = bus[7:0]; v.en = en[0]; v.rn = rn[0]; v.mn = mn[0];
        v.hold = hold[0]; v.busy = busy[0]; v.done = done[0]; v.addr = addr[3:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_mem();
        @(negedge i_clk);
        clr_mem = 1'b1;
        @(negedge i_clk);
        clr_mem = 1'b0;
    endtask

    // One load run, started at cycle 0; counts cycles until IDLE (bounded).
    task automatic run(input int stall_at, input int abort_at, input int restart_at,
                       output int done_cyc, output int done_cnt, output int idle_cyc,
                       output int n_addr, output int addr_bad);
        int stall_left;
        done_cyc = -1; done_cnt = 0; idle_cyc = -1; n_addr = 0; addr_bad = 0;
        stall_left = 5;
        @(negedge i_clk);
        i_start = 1'b1; i_abort = 1'b0; i_valid = 1'b1; i_data = 8'h10;
        for (int c = 1; c <= 80 && idle_cyc < 0; c++) begin
            @(negedge i_clk);
            i_start = 1'b0; i_abort = 1'b0; i_valid = 1'b1;
            if (o_done) begin done_cnt++; done_cyc = c; end
            if (!o_busy) idle_cyc = c;
            if (!o_reg_mem_write_n) begin
                if (o_bus != 8'(n_addr)) addr_bad++;
                n_addr++;
            end
            i_data = 8'h10 + 8'(o_addr);
            if (o_ready) begin
                if (o_addr == stall_at && stall_left > 0) begin
                    i_valid = 1'b0;
                    stall_left--;
                end
                if (o_addr == abort_at) i_abort = 1'b1;
                if (o_addr == restart_at) i_start = 1'b1;
            end
        end
        i_valid = 1'b0;
    endtask

    vec_t tbl [12];
    int dc, dn, ic, na, ab;
    bit hit;

    initial begin
        i_reset = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_valid = 1'b0; i_data = 8'h00;
        //            st ab vl dt    rdy bus  en rn mn ho bu dn addr
        tbl[0]  = mk(1, 1, 0, 'h00, 0, 'h00, 0, 1, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 'h00, 0, 'h00, 0, 1, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 'h00, 0, 'h00, 1, 0, 1, 1, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 'h77, 1, 'h00, 0, 1, 1, 1, 1, 0, 0);
        tbl[4]  = mk(0, 0, 1, 'hA5, 1, 'h00, 0, 1, 1, 1, 1, 0, 0);
        tbl[5]  = mk(1, 0, 0, 'h00, 0, 'hA5, 1, 1, 0, 1, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 'h00, 0, 'h01, 1, 0, 1, 1, 1, 0, 1);
        tbl[7]  = mk(0, 1, 1, 'h3C, 1, 'h00, 0, 1, 1, 1, 1, 0, 1);
        tbl[8]  = mk(0, 0, 0, 'h00, 0, 'h00, 0, 1, 1, 0, 0, 0, 1);
        tbl[9]  = mk(1, 0, 0, 'h00, 0, 'h00, 0, 1, 1, 0, 0, 0, 1);
        tbl[10] = mk(0, 1, 0, 'h00, 0, 'h00, 1, 0, 1, 1, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 'h00, 0, 'h00, 0, 1, 1, 0, 0, 0, 0);

        repeat (2) @(negedge i_clk);
        chk("reset_outputs", 32'(outs()), 32'(RST_OUT));
        i_reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            i_start = tbl[i].st; i_abort = tbl[i].ab; i_valid = tbl[i].vl; i_data = tbl[i].dt;
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({tbl[i].rdy, tbl[i].bus, tbl[i].en, tbl[i].rn, tbl[i].mn,
                     tbl[i].hold, tbl[i].busy, tbl[i].done, tbl[i].addr}));
        end
        @(negedge i_clk);
        chk("vec_mem0", 32'(mem[0]), 32'h0000_00A5);

        // Full load with the source always valid.
        clear_mem();
        run(-1, -1, -1, dc, dn, ic, na, ab);
        chk("full_done_cyc", dc, 49);
        chk("full_done_cnt", dn, 1);
        chk("full_idle_cyc", ic, 50);
        chk("full_addr_cnt", na, 16);
        chk("full_addr_seq", ab, 0);
        for (int k = 0; k < 16; k++) chk($sformatf("full_mem%0d", k), 32'(mem[k]), 32'(8'h10 + 8'(k)));

        // Source stalls five cycles on byte 3.
        run(3, -1, -1, dc, dn, ic, na, ab);
        chk("stall_done_cyc", dc, 54);
        chk("stall_idle_cyc", ic, 55);
        chk("stall_addr_seq", ab, 0);

        // Abort while waiting for byte 7.
        clear_mem();
        run(-1, 7, -1, dc, dn, ic, na, ab);
        chk("abort_done_cnt", dn, 0);
        chk("abort_idle_cyc", ic, 24);
        chk("abort_addr_cnt", na, 8);
        chk("abort_o_addr", 32'(o_addr), 7);
        chk("abort_hold", 32'(o_cpu_hold), 0);
        for (int k = 0; k < 16; k++)
            chk($sformatf("abort_mem%0d", k), 32'(mem[k]), (k < 7) ? 32'(8'h10 + 8'(k)) : 32'h0000_00EE);

        // Start pulse mid-load is ignored.
        run(-1, -1, 4, dc, dn, ic, na, ab);
        chk("restart_done_cyc", dc, 49);
        chk("restart_done_cnt", dn, 1);
        chk("restart_addr_cnt", na, 16);
        chk("restart_addr_seq", ab, 0);

        // Asynchronous reset in the middle of the DATA cycle for byte 2.
        clear_mem();
        @(negedge i_clk);
        i_start = 1'b1; i_valid = 1'b1; i_data = 8'h10;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge i_clk);
            i_start = 1'b0;
            i_data = 8'h10 + 8'(o_addr);
            if (!o_mem_write_n && o_addr == 4'd2) hit = 1'b1;
        end
        chk("rst_reach_data2", 32'(hit), 1);
        i_reset = 1'b0;
        #1;
        chk("rst_async_outputs", 32'(outs()), 32'(RST_OUT));
        i_valid = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        chk("rst_release_idle", 32'(outs()), 32'(RST_OUT));
        @(negedge i_clk);
        chk("rst_mem0", 32'(mem[0]), 32'h10);
        chk("rst_mem1", 32'(mem[1]), 32'h11);
        chk("rst_mem2", 32'(mem[2]), 32'hEE);

        chk("bus_rules", bus_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
